// File: rtl/accumulator_drain.sv
// accumulator_drain: drains rows from a diagonally stored accumulator,
// deskews the lanes back into complete rows and streams them through a
// two-entry output FIFO with a valid/ready handshake.
module accumulator_drain #(
  parameter int RES_WIDTH = 31,
  parameter int LANES     = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [6:0]                       base_addr_i,
  input  logic [7:0]                       num_rows_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             acc_rd_en_o,
  output logic [6:0]                       acc_rd_addr_o,
  input  logic [LANES*(RES_WIDTH+1)-1:0]   acc_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [LANES*(RES_WIDTH+1)-1:0]   out_data_o,
  output logic [6:0]                       out_row_o,
  output logic                             out_last_o
);

  localparam int LW = RES_WIDTH + 1;
  localparam int DW = LANES * LW;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t       state_reg, state_next;
  logic [7:0]   k_reg, k_next;        // index of the next read to issue
  logic [6:0]   base_reg, base_next;
  logic [7:0]   n_reg, n_next;        // clamped row count of the job
  logic [7:0]   m_reg, m_next;        // rows pushed into the FIFO so far
  logic         vld_reg;              // acc_data_i carries read data this cycle
  logic         prod_reg;             // ... and that read completes a row
  logic         rd_en;

  logic [DW-1:0] data_mem [2];
  logic [6:0]    row_mem  [2];
  logic          last_mem [2];
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    count_reg;

  logic          push, pop;
  logic [2:0]    occ;                 // FIFO occupancy after this cycle, incl. arriving row
  logic [DW-1:0] row_data;

  assign push = vld_reg & prod_reg;
  assign pop  = out_valid_o & out_ready_i;
  assign occ  = {1'b0, count_reg} + {2'b00, push} - {2'b00, pop};

  // Next-state logic: fixed-rate fill, then reads throttled by FIFO space
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    n_next     = n_reg;
    m_next     = m_reg + {7'd0, push};
    rd_en      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          if (num_rows_i == 8'd0) begin
            state_next = S_DONE;
          end else begin
            base_next  = base_addr_i;
            n_next     = (num_rows_i > 8'd128) ? 8'd128 : num_rows_i;
            k_next     = 8'd0;
            m_next     = 8'd0;
            state_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        rd_en  = 1'b1;
        k_next = k_reg + 8'd1;
        if (k_reg == 8'd30) state_next = S_STREAM;
      end
      S_STREAM: begin
        if (occ < 3'd2) begin
          rd_en  = 1'b1;
          k_next = k_reg + 8'd1;
          if (k_reg == n_reg + 8'd30) state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (occ == 3'd0) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control registers and read-data tracking
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      k_reg     <= 8'd0;
      base_reg  <= 7'd0;
      n_reg     <= 8'd0;
      m_reg     <= 8'd0;
      vld_reg   <= 1'b0;
      prod_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      base_reg  <= base_next;
      n_reg     <= n_next;
      m_reg     <= m_next;
      vld_reg   <= rd_en;
      prod_reg  <= rd_en && (k_reg >= 8'd31);
    end
  end

  assign busy_o        = (state_reg != S_IDLE);
  assign done_o        = (state_reg == S_DONE);
  assign acc_rd_en_o   = rd_en;
  assign acc_rd_addr_o = rd_en ? (base_reg + k_reg[6:0]) : 7'd0;

  // Deskew: lane gi is delayed by LANES-1-gi data arrivals so a full row lines up
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == LANES - 1) begin : g_direct
        assign row_data[gi*LW +: LW] = acc_data_i[gi*LW +: LW];
      end else begin : g_delay
        localparam int DEPTH = LANES - 1 - gi;
        logic [LW-1:0] sr_reg [DEPTH];
        // Shift only when the accumulator returned data this cycle
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            for (int s = 0; s < DEPTH; s++) sr_reg[s] <= '0;
          end else if (vld_reg) begin
            sr_reg[0] <= acc_data_i[gi*LW +: LW];
            for (int s = 1; s < DEPTH; s++) sr_reg[s] <= sr_reg[s-1];
          end
        end
        assign row_data[gi*LW +: LW] = sr_reg[DEPTH-1];
      end
    end
  endgenerate

  // Two-entry output FIFO holding completed rows
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int e = 0; e < 2; e++) begin
        data_mem[e] <= '0;
        row_mem[e]  <= 7'd0;
        last_mem[e] <= 1'b0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr_reg] <= row_data;
        row_mem[wr_ptr_reg]  <= base_reg + m_reg[6:0];
        last_mem[wr_ptr_reg] <= (m_reg == n_reg - 8'd1);
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_valid_o = (count_reg != 2'd0);
  assign out_data_o  = data_mem[rd_ptr_reg];
  assign out_row_o   = row_mem[rd_ptr_reg];
  assign out_last_o  = last_mem[rd_ptr_reg];

endmodule

// File: doc/accumulator_drain.md
ACCUMULATOR_DRAIN -- requirements
Module: accumulator_drain

Interface
REQ-001 Parameter: RES_WIDTH, default from tpu_package, lane MSB index (lane data width RES_WIDTH+1).
REQ-002 Parameter: LANES, default 32, number of accumulator columns; fixed at 32.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_i  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  single-cycle drain request, sampled only in IDLE.
REQ-007 base_addr_i  in  7  first accumulator row to drain.
REQ-008 num_rows_i  in  8  rows to drain; 0 = empty job; values >128 clamped to 128.
REQ-009 busy_o  out  1  high from the cycle after accepted start until done_o.
REQ-010 done_o  out  1  one-cycle pulse on job completion.
REQ-011 acc_rd_en_o  out  1  accumulator read-port enable.
REQ-012 acc_rd_addr_o  out  7  accumulator diagonal read address.
REQ-013 acc_data_i  in  32 x (RES_WIDTH+1)  read data, one cycle after acc_rd_en_o; lane j of a read at address a carries storage row (a-j) mod 128.
REQ-014 out_valid_o / out_ready_i  out/in  1 each  row-stream handshake; transfer when both high.
REQ-015 out_data_o  out  32 x (RES_WIDTH+1)  one complete, deskewed row.
REQ-016 out_row_o  out  7  accumulator row index of out_data_o.
REQ-017 out_last_o  out  1  high with the final row of the job.

Function
REQ-018 FSM states: IDLE, FILL, STREAM, FLUSH, DONE.
REQ-019 IDLE: start_i=1 with num_rows_i>0 latches base/count and enters FILL; with num_rows_i=0 enters DONE directly with no reads.
REQ-020 start_i outside IDLE is ignored; latched job parameters are not modified.
REQ-021 Read k (k = 0 .. N+30, N = clamped num_rows) uses address (base+k) mod 128; reads issue in strictly increasing k.
REQ-022 FILL covers reads 0..30, issued one per cycle unconditionally, first read in the cycle after start acceptance; then STREAM.
REQ-023 STREAM: read k>=31 issues only if (FIFO occupancy + output-producing reads in flight) < 2.
REQ-024 After read N+30 issues, enter FLUSH; leave FLUSH for DONE when no read is in flight and the FIFO is empty.
REQ-025 DONE lasts one cycle: done_o=1, busy_o=0 next cycle, return to IDLE.
REQ-026 Deskew: lane j delayed (31-j) data-arrival events (lane 31 no delay); shift registers advance only in cycles where acc_data_i is valid (acc_rd_en_o high previous cycle).
REQ-027 Row m (m = 0..N-1) completes on arrival of read m+31 and is pushed into a 2-entry output FIFO with out_row_o = (base+m) mod 128.
REQ-028 Lane data from rows before base (read k<j) is never emitted.
REQ-029 Data is passed unmodified, full RES_WIDTH+1 bits; no arithmetic, no saturation.
REQ-030 Latency with out_ready_i held high: start accepted at edge 0 -> first read in cycle 1 -> out_valid_o first high in cycle 34 -> one row per cycle thereafter.
REQ-031 out_valid_o, once high, holds with stable out_data_o/out_row_o/out_last_o until accepted.
REQ-032 FIFO never overflows; no row lost or duplicated under any out_ready_i pattern.
REQ-033 acc_rd_addr_o is 0 whenever acc_rd_en_o is 0.

Reset
REQ-034 rst_i low asynchronously forces IDLE, empties FIFO and deskew, in-flight counters 0.
REQ-035 During reset all outputs 0: busy_o, done_o, acc_rd_en_o, acc_rd_addr_o, out_valid_o, out_data_o, out_row_o, out_last_o.
REQ-036 Reset mid-job abandons the job with no done_o; the first start after release begins a fresh job.

Verification
REQ-037 Reset check: assert rst_i=0 during random activity -> all outputs 0 immediately; after release, IDLE with busy_o=0.
REQ-038 base=0, N=4, storage[r][j]=r*256+j, ready high -> reads addr 0..34 in cycles 1..35, rows 0..3 in cycles 34..37, out_last_o with row 3, done_o cycle 38.
REQ-039 Wrap: base=126, N=4 -> read addresses 126,127,0..32; out_row_o 126,127,0,1 with matching data.
REQ-040 Backpressure: N=16, out_ready_i low cycles 40..49 -> acc_rd_en_o drops within 2 cycles, at most 2 rows buffered, all 16 rows delivered in order afterwards.
REQ-041 start_i pulsed while busy -> ignored, job unchanged; start with num_rows_i=0 -> no reads, done_o pulse 1 cycle later.
REQ-042 N=200 -> clamped to 128 rows, 159 reads, out_last_o on row (base+127) mod 128.
